// File: rtl/serial_rx_param.sv
// Oversampling asynchronous serial receiver with majority-vote bit windows, parity/stop checking
// and an output FIFO. Define SERIAL_RX_BREAK_EN to add line-break detection (line_break, BRK_WAIT).
module serial_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sample_en,
  input  logic                                serial,
  output logic [DATA_BITS-1:0]                msg_data,
  output logic                                msg_valid,
  input  logic                                msg_ready,
  output logic                                parity_err,
  output logic                                frame_err,
  output logic                                overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
`ifdef SERIAL_RX_BREAK_EN
  ,
  output logic                                line_break
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int HW = $clog2(OVERSAMPLE + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [HW:0]   OS_CMP    = (HW+1)'(OVERSAMPLE);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4
`ifdef SERIAL_RX_BREAK_EN
    ,
    BRK_WAIT = 3'd5
`endif
  } state_t;

  logic                 sync1_q, sync2_q;
  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [HW-1:0]        high_q, high_d, h_new;
  logic [HW:0]          h2;
  logic [3:0]           bit_q, bit_d;
  logic                 par_drop_q, par_drop_d, stop_bad_q, stop_bad_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
  logic                 serial_s, in_win, win_end, bit_val, push, pop, full;
`ifdef SERIAL_RX_BREAK_EN
  logic                 first_low_q, first_low_d, lb_q, lb_d, brk;
`endif

  assign serial_s   = sync2_q;
  assign msg_valid  = (level_q != '0);
  assign msg_data   = msg_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;
`ifdef SERIAL_RX_BREAK_EN
  assign line_break = lb_q;
`endif

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    high_d     = high_q;
    bit_d      = bit_q;
    par_drop_d = par_drop_q;
    stop_bad_d = stop_bad_q;
    shift_d    = shift_q;
    pe_d       = 1'b0;
    fe_d       = 1'b0;
    ov_d       = 1'b0;
    push       = 1'b0;
`ifdef SERIAL_RX_BREAK_EN
    first_low_d = first_low_q;
    lb_d        = 1'b0;
    brk         = 1'b0;
`endif
    pop     = msg_valid & msg_ready;
    full    = (level_q == LW'(FIFO_DEPTH));
    in_win  = (state_q == START) || (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
    h_new   = high_q + HW'(serial_s);
    h2      = {h_new, 1'b0};
    // Majority vote over the window; a tie counts as a 1.
    bit_val = (h2 >= OS_CMP);
    win_end = sample_en && in_win && (tick_q == TICK_LAST);

    if (sample_en && in_win) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        high_d = '0;
      end else begin
        tick_d = tick_q + TW'(1);
        high_d = h_new;
      end
    end

    case (state_q)
      IDLE: if (sample_en && !serial_s) begin
        state_d    = START;
        tick_d     = '0;
        high_d     = '0;
        bit_d      = '0;
        par_drop_d = 1'b0;
        stop_bad_d = 1'b0;
      end
      START: if (win_end) state_d = bit_val ? IDLE : DATA;
      DATA: if (win_end) begin
        shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
        if (bit_q == DATA_LAST) begin
          bit_d   = '0;
          state_d = (PARITY_MODE != 0) ? PARITY : STOP;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      PARITY: if (win_end) begin
        if ((^shift_q ^ bit_val) != ODD) par_drop_d = 1'b1;
        state_d = STOP;
      end
      STOP: if (win_end) begin
        if (!bit_val) stop_bad_d = 1'b1;
`ifdef SERIAL_RX_BREAK_EN
        if (bit_q == 4'd0) first_low_d = !bit_val;
`endif
        if (bit_q == STOP_LAST) begin
          bit_d   = '0;
          state_d = IDLE;
          // Exactly one outcome per frame, highest priority first.
`ifdef SERIAL_RX_BREAK_EN
          brk = (shift_q == '0) && ((bit_q == 4'd0) ? !bit_val : first_low_q);
          if (brk) begin
            lb_d    = 1'b1;
            state_d = BRK_WAIT;
          end else
`endif
          if (stop_bad_q || !bit_val) fe_d = 1'b1;
          else if (par_drop_q)        pe_d = 1'b1;
          else if (full && !pop)      ov_d = 1'b1;
          else                        push = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
`ifdef SERIAL_RX_BREAK_EN
      BRK_WAIT: if (sample_en && serial_s) state_d = IDLE;
`endif
      default: begin
        state_d    = IDLE;
        tick_d     = '0;
        high_d     = '0;
        bit_d      = '0;
        par_drop_d = 1'b0;
        stop_bad_d = 1'b0;
      end
    endcase

    // A push while full is legal only because the head leaves on this same edge.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      tick_q     <= '0;
      high_q     <= '0;
      bit_q      <= '0;
      par_drop_q <= 1'b0;
      stop_bad_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
`ifdef SERIAL_RX_BREAK_EN
      first_low_q <= 1'b0;
      lb_q        <= 1'b0;
`endif
    end else begin
      sync1_q    <= serial;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      tick_q     <= tick_d;
      high_q     <= high_d;
      bit_q      <= bit_d;
      par_drop_q <= par_drop_d;
      stop_bad_q <= stop_bad_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
`ifdef SERIAL_RX_BREAK_EN
      first_low_q <= first_low_d;
      lb_q        <= lb_d;
`endif
    end
  end

  // Datapath storage carries no reset; the output is gated by msg_valid.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    mem_q   <= mem_d;
  end

endmodule

// File: doc/serial_rx_param.md
# serial_rx_param

Parametrised oversampling asynchronous serial receiver for the speed-tracker display CPLD. It extends the display's serial link with configurable data width, oversample ratio, parity mode and stop-bit count. It adds a line synchroniser, per-frame error reporting, and an output FIFO with a valid/ready handshake. It sits between the radar-side serial line and the display decode logic.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9, LSB first.
- `OVERSAMPLE`, 8: `sample_en` ticks per bit, power of 2, legal 4..16.
- `PARITY_MODE`, 1: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `FIFO_DEPTH`, 4: received-word FIFO entries, power of 2, ≥2.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sample_en` in 1: oversample tick at OVERSAMPLE × baud; may be tied high.
- `serial` in 1: asynchronous serial line, idle high.
- `msg_data` out DATA_BITS: FIFO head word.
- `msg_valid` out 1: FIFO non-empty.
- `msg_ready` in 1: consumer accepts head when `msg_valid & msg_ready`.
- `parity_err` out 1: one-clk pulse, frame dropped on parity mismatch.
- `frame_err` out 1: one-clk pulse, frame dropped on low stop bit.
- `overrun` out 1: one-clk pulse, good frame dropped because FIFO full.
- `fifo_level` out $clog2(FIFO_DEPTH+1): occupied entries.
- `line_break` out 1: one-clk pulse; present only with `SERIAL_RX_BREAK_EN`.

## Operation
- `serial` passes through a 2-flop synchroniser whose flops reset to 1. All sampling uses the synchronised value.
- FSM states: IDLE, START, DATA, PARITY, STOP, plus BRK_WAIT when `SERIAL_RX_BREAK_EN` is defined. FSM and window counters advance only on `sample_en`.
- IDLE: a low sample moves to START. That detecting tick is not counted.
- Each bit window is OVERSAMPLE ticks. It counts high samples `h` in a $clog2(OVERSAMPLE+1)-bit counter. The bit value is 1 iff `2*h >= OVERSAMPLE`, so ties resolve to 1.
- START: resolved 1 is a false start and returns to IDLE with no flag. Resolved 0 goes to DATA.
- DATA: DATA_BITS windows, shifted LSB first. The next state is PARITY if PARITY_MODE≠0, else STOP.
- PARITY: for even mode, XOR of data and parity bit must be 0; for odd mode, it must be 1. A mismatch sets an internal drop flag. Reception continues into STOP, so there is no resync mid-frame.
- STOP: STOP_BITS windows. Any stop bit resolving to 0 makes the frame bad.
- At the end of the final stop window:
  - Bad stop: pulse `frame_err`.
  - Otherwise, parity drop: pulse `parity_err`.
  - Otherwise, FIFO full with no pop this clk: pulse `overrun`.
  - Otherwise, push the data word.
  - At most one flag pulses per frame. The FSM then returns to IDLE.
- FIFO:
  - Circular buffer with read/write pointers.
  - Push and pop in the same clk are both honoured, including when full (the push is accepted) and when empty with no pop possible (`msg_valid` is 0, so only the push occurs).
  - Pointers wrap modulo FIFO_DEPTH.
- Illegal FSM encodings return to IDLE with counters cleared.

## Timing
- Reset values:
  - `msg_data` = 0.
  - `msg_valid`, `parity_err`, `frame_err`, `overrun`, `line_break` = 0.
  - `fifo_level` = 0.
  - FSM = IDLE, counters cleared, synchroniser = 1.
- Reset asserted mid-frame or with the FIFO non-empty discards everything immediately and asynchronously.
- `serial` to FSM input latency: 2 clk.
- Push occurs on the clk of the final stop window's last `sample_en`. `msg_valid` rises the next clk if the FIFO was empty. `fifo_level` updates on the same edge as the push.
- Pop: the head advances on the clk edge where `msg_valid & msg_ready`. `msg_data` shows the next entry the following cycle.
- Error pulses are registered, one clk wide, and aligned with the would-be push edge.

## Configuration
- Macro: `SERIAL_RX_BREAK_EN`.
- Defined:
  - A frame with all data bits 0 and a low first stop bit pulses `line_break` instead of `frame_err`.
  - The FSM then enters BRK_WAIT and stays until a high sample, then goes to IDLE.
  - Nothing is pushed.
- Undefined:
  - The `line_break` port and BRK_WAIT do not exist.
  - Such frames pulse `frame_err` and return to IDLE directly.
  - A held-low line therefore produces repeated frame-error frames.

## Test plan
- Send 0xA5 with even parity (parity bit 0), 1 stop, `sample_en`=1, OVERSAMPLE=8, `msg_ready`=0 → `msg_data`=0xA5, `msg_valid`=1, `fifo_level`=1, no error pulses.
- Send 0xA5 with parity bit 1 → one `parity_err` pulse, `fifo_level` stays 0, next good frame 0x3C is received correctly.
- Send a 3-tick low glitch on an idle line → START resolves 1, no push, no flags, FSM returns to IDLE.
- Send 0x3C with stop bit low, STOP_BITS=2 and second stop low → `frame_err` pulse, no push.
- With FIFO_DEPTH=4 and `msg_ready`=0, send 5 frames 0x01..0x05 → `fifo_level`=4, `overrun` on the 5th. Then pop with `msg_ready`=1 and read 0x01..0x04 in order. A push coinciding with a pop while full is accepted.
- With `SERIAL_RX_BREAK_EN`, hold `serial` low for 20 bit times → one `line_break`, no `frame_err`, no further pulses until the line goes high. Then 0x55 is received. Assert `rst` mid-frame → all outputs return to reset values.
